// File: rtl/timer_share_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// timer_share_arbiter_pkg: shared state encodings and timer defaults. rev 1.0
// ============================================================================
package timer_share_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

  localparam int DEFAULT_TICKS_PER_SEC = 50_000_000;
  localparam int DEFAULT_SECONDS       = 3;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/timer_share_arbiter_sec_countdown.sv
`default_nettype none
// ============================================================================
// timer_share_arbiter_sec_countdown: tick prescaler and whole-second countdown. rev 1.0
// ============================================================================
module timer_share_arbiter_sec_countdown
  import timer_share_arbiter_pkg::*;
#(
  parameter int TICKS_PER_SEC = DEFAULT_TICKS_PER_SEC,
  parameter int SECONDS       = DEFAULT_SECONDS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       run_i,
  output logic [3:0] remaining_sec_o,
  output logic       expire_o
);

  localparam int            TW        = cnt_width(TICKS_PER_SEC);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);
  localparam logic [3:0]    SEC_INIT  = 4'(SECONDS);

  logic [TW-1:0] tick_q, tick_d;
  logic [3:0]    sec_q, sec_d;
  logic          tick_wrap;

  assign tick_wrap = (tick_q == TICK_LAST);

  // Neither loading nor running clears both counters, so idle reads as zero.
  always_comb begin
    tick_d = '0;
    sec_d  = '0;
    if (load_i) begin
      tick_d = '0;
      sec_d  = SEC_INIT;
    end else if (run_i) begin
      if (tick_wrap) begin
        tick_d = '0;
        sec_d  = sec_q - 4'd1;
      end else begin
        tick_d = tick_q + TW'(1);
        sec_d  = sec_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q <= '0;
      sec_q  <= '0;
    end else begin
      tick_q <= tick_d;
      sec_q  <= sec_d;
    end
  end

  assign remaining_sec_o = sec_q;
  // Last tick of the last second; the owner gates this with its run state.
  assign expire_o        = tick_wrap && (sec_q == 4'd1);

endmodule
`default_nettype wire

// File: rtl/timer_share_arbiter.sv
`default_nettype none
// ============================================================================
// timer_share_arbiter: round-robin sharing of one seconds countdown. rev 1.0
// ============================================================================
module timer_share_arbiter
  import timer_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = 3,
  parameter int TICKS_PER_SEC = DEFAULT_TICKS_PER_SEC,
  parameter int SECONDS       = DEFAULT_SECONDS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] timeout,
  output logic               busy,
  output logic [3:0]         remaining_sec
);

  localparam int          PW     = cnt_width(NUM_REQ);
  localparam logic [PW:0] CAND_N = (PW + 1)'(NUM_REQ);

  arb_state_e         state_q, state_d;
  logic [PW-1:0]      owner_q, owner_d;
  logic [PW-1:0]      rr_q, rr_d;
  logic [NUM_REQ-1:0] armed_q, armed_d;

  logic [NUM_REQ-1:0] elig;
  logic [PW:0]        cand;
  logic               pick_valid;
  logic [PW-1:0]      pick_idx;
  logic [PW-1:0]      owner_next;
  logic               owner_req;
  logic               cd_load;
  logic               cd_run;
  logic               cd_expire;

  assign elig       = req & armed_q;
  assign owner_req  = req[owner_q];
  assign owner_next = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + PW'(1);

  // Scan from the farthest offset back to rr_q so the nearest eligible index wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_q} + (PW + 1)'(k);
      if (cand >= CAND_N) begin
        cand = cand - CAND_N;
      end
      if (elig[cand[PW-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    armed_d = armed_q | ~req;
    cd_load = 1'b0;
    cd_run  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          owner_d = pick_idx;
          cd_load = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // A dropped owner request aborts even on the expiry cycle.
        if (!owner_req) begin
          state_d = ST_IDLE;
          rr_d    = owner_next;
        end else begin
          cd_run = 1'b1;
          if (cd_expire) begin
            state_d          = ST_DONE;
            rr_d             = owner_next;
            armed_d[owner_q] = 1'b0;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      armed_q <= '1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      armed_q <= armed_d;
    end
  end

  timer_share_arbiter_sec_countdown #(
    .TICKS_PER_SEC (TICKS_PER_SEC),
    .SECONDS       (SECONDS)
  ) u_sec_countdown (
    .clk             (clk),
    .rst             (rst),
    .load_i          (cd_load),
    .run_i           (cd_run),
    .remaining_sec_o (remaining_sec),
    .expire_o        (cd_expire)
  );

  assign busy = (state_q != ST_IDLE);

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_out
    assign grant[gi]   = (state_q != ST_IDLE) && (owner_q == PW'(gi));
    assign timeout[gi] = (state_q == ST_DONE) && (owner_q == PW'(gi));
  end

endmodule
`default_nettype wire

// File: tb/tb_timer_share_arbiter.sv
`default_nettype none
// ============================================================================
// tb_timer_share_arbiter: scoreboard bench, NUM_REQ=3 TICKS_PER_SEC=4 SECONDS=3. rev 1.0
// ============================================================================
module tb_timer_share_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req = 3'b000;
  logic [2:0] grant;
  logic [2:0] timeout;
  logic       busy;
  logic [3:0] remaining_sec;

  always #5 clk = ~clk;

  timer_share_arbiter #(
    .NUM_REQ       (3),
    .TICKS_PER_SEC (4),
    .SECONDS       (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .grant         (grant),
    .timeout       (timeout),
    .busy          (busy),
    .remaining_sec (remaining_sec)
  );

  typedef struct {
    int         cyc;
    logic [2:0] val;
  } ev_t;

  typedef struct {
    int         cyc;
    logic [2:0] g;
    logic [2:0] to;
    logic       b;
    logic [3:0] rem;
  } snap_t;

  ev_t   gq[$];
  ev_t   tq[$];
  snap_t sq[$];
  ev_t   me;
  snap_t ms;

  int         cyc   = 0;
  int         base  = 0;
  int         total = 0;
  int         bad   = 0;
  logic [2:0] prev_grant = 3'b000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (cycle %0d): got %0h required %0h", name, cyc - base, act, exp);
    end
  endtask

  // Monitor: pops expected events as the DUT presents them.
  always @(negedge clk) begin
    if (!rst) begin
      if (grant !== prev_grant) begin
        if (gq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL grant_unexpected (cycle %0d): got %b required no change", cyc - base, grant);
        end else begin
          me = gq.pop_front();
          check("grant_cycle", cyc - base, me.cyc - base);
          check("grant_value", {29'd0, grant}, {29'd0, me.val});
        end
      end
      if (timeout !== 3'b000) begin
        if (tq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL timeout_unexpected (cycle %0d): got %b required 000", cyc - base, timeout);
        end else begin
          me = tq.pop_front();
          check("timeout_cycle", cyc - base, me.cyc - base);
          check("timeout_value", {29'd0, timeout}, {29'd0, me.val});
        end
      end
    end
    prev_grant = grant;
    while (sq.size() > 0 && sq[0].cyc <= cyc) begin
      ms = sq.pop_front();
      if (ms.cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL snapshot_missed: got cycle %0d required %0d", cyc - base, ms.cyc - base);
      end else begin
        check("snap_grant", {29'd0, grant}, {29'd0, ms.g});
        check("snap_timeout", {29'd0, timeout}, {29'd0, ms.to});
        check("snap_busy", {31'd0, busy}, {31'd0, ms.b});
        check("snap_remaining", {28'd0, remaining_sec}, {28'd0, ms.rem});
      end
    end
  end

  task automatic start_test(input logic [2:0] r);
    rst = 1'b1;
    req = 3'b000;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    base = cyc;
    req  = r;
  endtask

  task automatic at(input int k);
    while (cyc < base + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic void eg(input int k, input logic [2:0] v);
    gq.push_back('{base + k, v});
  endfunction

  function automatic void eto(input int k, input logic [2:0] v);
    tq.push_back('{base + k, v});
  endfunction

  function automatic void es(input int k, input logic [2:0] g, input logic [2:0] to,
                             input logic b, input logic [3:0] rem);
    sq.push_back('{base + k, g, to, b, rem});
  endfunction

  task automatic end_test(input string name);
    check({name, "_grant_left"}, gq.size(), 0);
    check({name, "_timeout_left"}, tq.size(), 0);
    check({name, "_snap_left"}, sq.size(), 0);
    gq.delete();
    tq.delete();
    sq.delete();
  endtask

  initial begin
    // Single requester, then re-arm by a one-cycle drop.
    start_test(3'b001);
    es(0, 3'b000, 3'b000, 1'b0, 4'd0);
    es(1, 3'b001, 3'b000, 1'b1, 4'd3);
    es(4, 3'b001, 3'b000, 1'b1, 4'd3);
    es(5, 3'b001, 3'b000, 1'b1, 4'd2);
    es(9, 3'b001, 3'b000, 1'b1, 4'd1);
    es(12, 3'b001, 3'b000, 1'b1, 4'd1);
    es(13, 3'b001, 3'b001, 1'b1, 4'd0);
    es(14, 3'b000, 3'b000, 1'b0, 4'd0);
    es(20, 3'b000, 3'b000, 1'b0, 4'd0);
    es(22, 3'b001, 3'b000, 1'b1, 4'd3);
    es(33, 3'b001, 3'b000, 1'b1, 4'd1);
    es(34, 3'b001, 3'b001, 1'b1, 4'd0);
    es(35, 3'b000, 3'b000, 1'b0, 4'd0);
    eg(1, 3'b001); eg(14, 3'b000); eg(22, 3'b001); eg(35, 3'b000);
    eto(13, 3'b001); eto(34, 3'b001);
    at(20); req = 3'b000;
    at(21); req = 3'b001;
    at(40);
    end_test("single");

    // Contention: all three held, round-robin order, then re-arm of 0.
    start_test(3'b111);
    es(0, 3'b000, 3'b000, 1'b0, 4'd0);
    es(1, 3'b001, 3'b000, 1'b1, 4'd3);
    es(13, 3'b001, 3'b001, 1'b1, 4'd0);
    es(15, 3'b010, 3'b000, 1'b1, 4'd3);
    es(27, 3'b010, 3'b010, 1'b1, 4'd0);
    es(29, 3'b100, 3'b000, 1'b1, 4'd3);
    es(41, 3'b100, 3'b100, 1'b1, 4'd0);
    es(44, 3'b000, 3'b000, 1'b0, 4'd0);
    es(47, 3'b001, 3'b000, 1'b1, 4'd3);
    eg(1, 3'b001); eg(14, 3'b000); eg(15, 3'b010); eg(28, 3'b000);
    eg(29, 3'b100); eg(42, 3'b000); eg(47, 3'b001);
    eto(13, 3'b001); eto(27, 3'b010); eto(41, 3'b100);
    at(45); req = 3'b110;
    at(46); req = 3'b111;
    at(50);
    end_test("contention");

    // Abort by owner drop; pending requester 2 granted afterwards.
    start_test(3'b010);
    es(0, 3'b000, 3'b000, 1'b0, 4'd0);
    es(1, 3'b010, 3'b000, 1'b1, 4'd3);
    es(6, 3'b010, 3'b000, 1'b1, 4'd2);
    es(7, 3'b000, 3'b000, 1'b0, 4'd0);
    es(8, 3'b100, 3'b000, 1'b1, 4'd3);
    eg(1, 3'b010); eg(7, 3'b000); eg(8, 3'b100);
    at(2); req = 3'b110;
    at(6); req = 3'b100;
    at(15);
    end_test("abort");

    // Abort in the expiry cycle suppresses the pulse.
    start_test(3'b001);
    es(0, 3'b000, 3'b000, 1'b0, 4'd0);
    es(1, 3'b001, 3'b000, 1'b1, 4'd3);
    es(12, 3'b001, 3'b000, 1'b1, 4'd1);
    es(13, 3'b000, 3'b000, 1'b0, 4'd0);
    es(14, 3'b000, 3'b000, 1'b0, 4'd0);
    eg(1, 3'b001); eg(13, 3'b000);
    at(12); req = 3'b000;
    at(18);
    end_test("abort_expiry");

    // Asynchronous reset mid-countdown, then a fresh grant.
    start_test(3'b001);
    es(0, 3'b000, 3'b000, 1'b0, 4'd0);
    es(1, 3'b001, 3'b000, 1'b1, 4'd3);
    es(6, 3'b001, 3'b000, 1'b1, 4'd2);
    es(7, 3'b000, 3'b000, 1'b0, 4'd0);
    es(8, 3'b000, 3'b000, 1'b0, 4'd0);
    es(10, 3'b001, 3'b000, 1'b1, 4'd3);
    es(14, 3'b001, 3'b000, 1'b1, 4'd2);
    eg(1, 3'b001); eg(10, 3'b001);
    at(7); rst = 1'b1;
    at(9); rst = 1'b0;
    at(16);
    end_test("reset_mid_run");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
